mux_scan: RTL and testbench
===========================

Name: mux_scan

Overview:
Parametrised, registered N-channel data selector. It succeeds the fixed 3-channel combinational selector. Each channel carries DATA_W bits plus one status flag (overflow-style) that is optionally appended as the output MSB. Three modes:
- Manual select.
- Auto-scan: channels rotate with a programmable dwell time, for time-multiplexed displays.
- Hold: output frozen.

It sits between the arithmetic/status sources and the display/output driver.

Parameters:
NUM_CH, 4, number of input channels (2..16)
DATA_W, 3, data bits per channel
SEL_W, 2, select/index width; must satisfy 2**SEL_W >= NUM_CH
CNT_W, 8, dwell counter width
FLAG_MASK, 4'b0010, per-channel enable for appending the flag bit (bit k = channel k)

Ports:
i_clk  in  1  system clock, rising-edge
i_rst  in  1  synchronous, active-high reset
i_mode  in  2  00 manual, 01 auto-scan, 10 hold, 11 hold (reserved)
i_sel  in  SEL_W  channel index in manual mode
i_data  in  NUM_CH*DATA_W  packed channel data; channel k at [k*DATA_W +: DATA_W]
i_flag  in  NUM_CH  per-channel status flag
i_dwell  in  CNT_W  auto-scan dwell; a channel is held for i_dwell+1 cycles
o_mux  out  DATA_W+1  selected output: {flag_k & FLAG_MASK[k], data_k}
o_ch  out  SEL_W  index of the channel currently driven on o_mux
o_valid  out  1  o_mux carries a legal channel
o_wrap  out  1  one-cycle pulse when auto-scan wraps from NUM_CH-1 to 0

Behaviour:
- One clock domain; reset is synchronous and active-high and dominates every other input.
- Reset values: o_mux=0, o_ch=0, o_valid=0, o_wrap=0, dwell counter=0.
- All outputs are registered. Latency is 1 cycle from i_sel/i_data/i_flag to o_mux.
- Extension rule: MSB = i_flag[ch] AND FLAG_MASK[ch]. Low DATA_W bits = channel data, zero-extended.
- Manual (00):
  - Each cycle, o_ch <= i_sel.
  - If i_sel < NUM_CH: o_mux <= extended channel, o_valid <= 1.
  - Else: o_mux <= 0, o_valid <= 0 (illegal select yields zero output).
  - Dwell counter is held at 0. o_wrap = 0.
- Auto-scan (01):
  - Dwell counter increments each cycle.
  - When counter >= i_dwell: counter <= 0 and o_ch advances by one.
  - When o_ch = NUM_CH-1 the advance goes to 0 and o_wrap pulses for exactly one cycle, aligned with the o_ch=0 update.
  - o_mux tracks live data of the channel indexed by the next o_ch value every cycle, not a snapshot.
  - o_valid = 1.
  - i_dwell = 0: advance every cycle.
  - i_dwell lowered below the current count: advance on the next cycle, because the comparison is >=.
- Entry to auto-scan:
  - Scan starts from the current o_ch with the counter cleared.
  - If o_ch >= NUM_CH (after an illegal manual select), it restarts at 0 with no o_wrap pulse.
- Hold (10/11):
  - o_mux, o_ch, o_valid and the dwell counter are frozen. o_wrap = 0.
  - Leaving hold for auto-scan resumes the counter from its frozen value.
- Mode change takes effect on the first edge where the new i_mode is sampled. No extra pipeline bubble.
- Simultaneous reset and any mode: reset wins. Reset mid-scan returns to channel 0, counter 0.

Decomposition:
- Shared package: mode encodings (MODE_MANUAL, MODE_SCAN, MODE_HOLD), a clog2 helper, and the channel-extension function (flag append).
- One natural sub-module, mux_scan_ctr: the dwell counter plus channel index advance/wrap logic. It takes mode, i_dwell and current index, and returns next index and the wrap strobe.
- Data selection and the output registers stay in the top module.

Test Plan:
1. Reset hold: i_rst=1 for 3 cycles with random inputs -> o_mux=0, o_ch=0, o_valid=0, o_wrap=0 throughout. Release -> first update one cycle later.
2. Manual select with flag: i_data ch1=3'b101, i_flag=4'b0010, i_sel=1 -> o_mux=4'b1101, o_valid=1 one cycle later. Same with i_sel=0 and i_flag=4'b0001 (mask=0) -> MSB=0.
3. Illegal select (NUM_CH=3, SEL_W=2): i_sel=3 -> o_mux=0, o_valid=0, o_ch=3. Then switch to auto-scan -> o_ch=0 with no o_wrap pulse.
4. Auto-scan dwell: i_dwell=2, NUM_CH=4 -> o_ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0. o_wrap=1 only on the cycle o_ch returns to 0. i_dwell=0 -> o_ch changes every cycle.
5. Hold and resume: hold entered mid-dwell (count=1) for 5 cycles -> outputs frozen even though i_data changes. Return to scan -> o_ch advances after 1 more cycle (i_dwell=1).
6. Reset mid-scan at o_ch=2 -> next cycle o_ch=0, counter 0, o_valid=0. Scan restarts after reset is released.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared definitions for the registered N-channel scan selector.
package mux_scan_pkg;

    // Mode encodings; 2'b11 behaves as hold.
    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_HOLD   = 2'b10;

    // Ceiling log2, used for elaboration-time width checks.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Channel extension: data zero-extended, flag (gated by its mask bit)
    // placed directly above the data. Supports DATA_W up to 16.
    function automatic logic [16:0] ext_ch(input logic [15:0] d, input logic f,
                                           input logic m, input int dw);
        logic [16:0] r;
        r     = {1'b0, d};
        r[dw] = f & m;
        return r;
    endfunction

endpackage

// File: rtl/mux_scan_ctr.sv
// Dwell counter and channel-index advance/wrap for auto-scan.
module mux_scan_ctr
    import mux_scan_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [1:0]       i_mode,
    input  logic [CNT_W-1:0] i_dwell,
    input  logic [SEL_W-1:0] i_ch,
    output logic [SEL_W-1:0] o_nxt_ch,
    output logic             o_wrap
);

    localparam logic [SEL_W:0] LAST = (SEL_W+1)'(NUM_CH - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_legal;
    logic             w_last;
    logic             w_expire;

    assign w_legal  = ({1'b0, i_ch} <= LAST);
    assign w_last   = ({1'b0, i_ch} == LAST);
    assign w_expire = (r_cnt >= i_dwell);

    // Next index / counter: manual parks the counter at 0, hold freezes it,
    // scan counts up and advances the index once the dwell has elapsed.
    always_comb begin
        o_nxt_ch  = i_ch;
        o_wrap    = 1'b0;
        w_cnt_nxt = r_cnt;
        if (i_mode == MODE_MANUAL) begin
            w_cnt_nxt = '0;
        end else if (i_mode == MODE_SCAN) begin
            if (!w_legal) begin
                // Illegal index left over from manual: restart quietly at 0.
                o_nxt_ch  = '0;
                w_cnt_nxt = '0;
            end else if (w_expire) begin
                w_cnt_nxt = '0;
                if (w_last) begin
                    o_nxt_ch = '0;
                    o_wrap   = 1'b1;
                end else begin
                    o_nxt_ch = i_ch + 1'b1;
                end
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    // Dwell counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_cnt <= '0;
        else       r_cnt <= w_cnt_nxt;
    end

endmodule

// File: rtl/mux_scan.sv
// Registered N-channel data selector with manual, auto-scan and hold modes.
module mux_scan
    import mux_scan_pkg::*;
#(
    parameter int                 NUM_CH    = 4,
    parameter int                 DATA_W    = 3,
    parameter int                 SEL_W     = 2,
    parameter int                 CNT_W     = 8,
    parameter logic [NUM_CH-1:0]  FLAG_MASK = NUM_CH'(4'b0010)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [1:0]               i_mode,
    input  logic [SEL_W-1:0]         i_sel,
    input  logic [NUM_CH*DATA_W-1:0] i_data,
    input  logic [NUM_CH-1:0]        i_flag,
    input  logic [CNT_W-1:0]         i_dwell,
    output logic [DATA_W:0]          o_mux,
    output logic [SEL_W-1:0]         o_ch,
    output logic                     o_valid,
    output logic                     o_wrap
);

    if (SEL_W < clog2(NUM_CH)) begin : g_bad_sel_w
        $error("mux_scan: SEL_W too narrow for NUM_CH");
    end

    localparam logic [SEL_W:0] NCH = (SEL_W+1)'(NUM_CH);

    logic [DATA_W:0]   r_mux;
    logic [SEL_W-1:0]  r_ch;
    logic              r_valid;
    logic              r_wrap;

    logic [SEL_W-1:0]  w_scan_ch;
    logic              w_scan_wrap;
    logic [SEL_W-1:0]  w_ch_nxt;
    logic              w_ok;
    logic [DATA_W-1:0] w_data_sel;
    logic              w_flag_sel;
    logic              w_mask_sel;
    logic [DATA_W:0]   w_ext;

    mux_scan_ctr #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W),
        .CNT_W  (CNT_W)
    ) u_ctr (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_mode   (i_mode),
        .i_dwell  (i_dwell),
        .i_ch     (r_ch),
        .o_nxt_ch (w_scan_ch),
        .o_wrap   (w_scan_wrap)
    );

    // Channel to drive next: manual takes i_sel, otherwise the counter's pick.
    assign w_ch_nxt = (i_mode == MODE_MANUAL) ? i_sel : w_scan_ch;
    assign w_ok     = ({1'b0, w_ch_nxt} < NCH);

    // Live data/flag of the next channel; equality decode keeps illegal
    // indices from ever slicing outside i_data.
    always_comb begin
        w_data_sel = '0;
        w_flag_sel = 1'b0;
        w_mask_sel = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_ch_nxt == SEL_W'(k)) begin
                w_data_sel = i_data[k*DATA_W +: DATA_W];
                w_flag_sel = i_flag[k];
                w_mask_sel = FLAG_MASK[k];
            end
        end
    end

    assign w_ext = (DATA_W+1)'(ext_ch(16'(w_data_sel), w_flag_sel, w_mask_sel, DATA_W));

    // Output registers; hold (either encoding) freezes everything but wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mux   <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (i_mode[1]) begin
            r_wrap  <= 1'b0;
        end else begin
            r_ch    <= w_ch_nxt;
            r_mux   <= w_ok ? w_ext : '0;
            r_valid <= w_ok;
            r_wrap  <= (i_mode == MODE_SCAN) & w_scan_wrap;
        end
    end

    assign o_mux   = r_mux;
    assign o_ch    = r_ch;
    assign o_valid = r_valid;
    assign o_wrap  = r_wrap;

endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan: a 4-channel and a 3-channel instance share stimulus
// and are compared against an integer-level model of the selector rules.
module tb_mux_scan;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic [11:0] data;
    logic [3:0]  flag;
    logic [7:0]  dwell;

    logic [3:0]  mux4, mux3;
    logic [1:0]  ch4, ch3;
    logic        v4, v3, w4, w3;

    mux_scan #(.NUM_CH(4), .DATA_W(3), .SEL_W(2), .CNT_W(8), .FLAG_MASK(4'b0010)) u4 (
        .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_sel(sel), .i_data(data),
        .i_flag(flag), .i_dwell(dwell), .o_mux(mux4), .o_ch(ch4), .o_valid(v4), .o_wrap(w4));

    mux_scan #(.NUM_CH(3), .DATA_W(3), .SEL_W(2), .CNT_W(8), .FLAG_MASK(3'b010)) u3 (
        .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_sel(sel), .i_data(data[8:0]),
        .i_flag(flag[2:0]), .i_dwell(dwell), .o_mux(mux3), .o_ch(ch3), .o_valid(v3), .o_wrap(w3));

    int checks = 0;
    int errors = 0;

    // Model state: index 0 = 4-channel instance, 1 = 3-channel instance.
    int nc[2] = '{4, 3};
    int m_ch[2], m_cnt[2], m_mux[2], m_val[2], m_wrap[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Extended value of channel c: 3 data bits, flag appended only for ch1.
    function automatic int ext(input int c);
        int d;
        d = (int'(data) >> (3 * c)) & 7;
        if (c == 1 && flag[c]) d += 8;
        return d;
    endfunction

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_ch[i] = 0; m_cnt[i] = 0; m_mux[i] = 0; m_val[i] = 0; m_wrap[i] = 0;
            end else if (mode == 2'd0) begin
                m_ch[i] = int'(sel); m_cnt[i] = 0; m_wrap[i] = 0;
                m_val[i] = (m_ch[i] < nc[i]) ? 1 : 0;
                m_mux[i] = m_val[i] ? ext(m_ch[i]) : 0;
            end else if (mode == 2'd1) begin
                m_wrap[i] = 0;
                if (m_ch[i] >= nc[i]) begin
                    m_ch[i] = 0; m_cnt[i] = 0;
                end else if (m_cnt[i] >= int'(dwell)) begin
                    m_cnt[i] = 0;
                    if (m_ch[i] == nc[i] - 1) m_wrap[i] = 1;
                    m_ch[i] = (m_ch[i] + 1) % nc[i];
                end else begin
                    m_cnt[i]++;
                end
                m_val[i] = 1;
                m_mux[i] = ext(m_ch[i]);
            end else begin
                m_wrap[i] = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("mux4",  32'(mux4), 32'(m_mux[0]));
        chk("ch4",   32'(ch4),  32'(m_ch[0]));
        chk("val4",  32'(v4),   32'(m_val[0]));
        chk("wrap4", 32'(w4),   32'(m_wrap[0]));
        chk("mux3",  32'(mux3), 32'(m_mux[1]));
        chk("ch3",   32'(ch3),  32'(m_ch[1]));
        chk("val3",  32'(v3),   32'(m_val[1]));
        chk("wrap3", 32'(w3),   32'(m_wrap[1]));
    endtask

    task automatic step(input logic r, input logic [1:0] md, input logic [1:0] s,
                        input logic [7:0] dw, input bit rnd);
        rst = r; mode = md; sel = s; dwell = dw;
        if (rnd) begin
            data = 12'($urandom);
            flag = 4'($urandom);
        end
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    initial begin
        int exp_seq[12] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
        int held_mux;
        rst = 1'b1; mode = '0; sel = '0; data = '0; flag = '0; dwell = '0;

        // Reset held with random inputs, then first update after release.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 2'($urandom), 2'($urandom), 8'($urandom), 1'b1);
            chk("rst_mux", 32'(mux4), 32'd0);
            chk("rst_val", 32'(v4), 32'd0);
        end
        step(1'b0, 2'd0, 2'd2, 8'd0, 1'b1);

        // Manual select with and without the masked flag.
        data = 12'b000_000_101_000; flag = 4'b0010;
        step(1'b0, 2'd0, 2'd1, 8'd0, 1'b0);
        chk("man_flag_mux", 32'(mux4), 32'b1101);
        chk("man_flag_val", 32'(v4), 32'd1);
        data = 12'b000_000_000_110; flag = 4'b0001;
        step(1'b0, 2'd0, 2'd0, 8'd0, 1'b0);
        chk("man_mask_mux", 32'(mux4), 32'b0110);

        // Illegal select on the 3-channel instance, then scan entry.
        step(1'b0, 2'd0, 2'd3, 8'd2, 1'b1);
        chk("ill_mux", 32'(mux3), 32'd0);
        chk("ill_val", 32'(v3), 32'd0);
        chk("ill_ch",  32'(ch3), 32'd3);
        step(1'b0, 2'd1, 2'd0, 8'd2, 1'b1);
        chk("ill_scan_ch",   32'(ch3), 32'd0);
        chk("ill_scan_wrap", 32'(w3), 32'd0);

        // Dwell 2 scan sequence from a clean reset.
        step(1'b1, 2'd0, 2'd0, 8'd2, 1'b1);
        chk("pre_seq_ch", 32'(ch4), 32'd0);
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 2'd1, 2'($urandom), 8'd2, 1'b1);
            chk("seq_ch", 32'(ch4), 32'(exp_seq[k]));
            chk("seq_wrap", 32'(w4), (k == 11) ? 32'd1 : 32'd0);
        end
        for (int k = 0; k < 5; k++) step(1'b0, 2'd1, 2'd0, 8'd0, 1'b1);

        // Hold entered mid-dwell, outputs frozen while data moves.
        for (int k = 0; k < 20 && m_cnt[0] != 1; k++) step(1'b0, 2'd1, 2'd0, 8'd1, 1'b1);
        chk("reach_cnt1", 32'(m_cnt[0]), 32'd1);
        held_mux = m_mux[0];
        for (int k = 0; k < 5; k++) begin
            step(1'b0, (k % 2) ? 2'd3 : 2'd2, 2'($urandom), 8'd1, 1'b1);
            chk("hold_mux", 32'(mux4), 32'(held_mux));
        end
        step(1'b0, 2'd1, 2'd0, 8'd1, 1'b1);
        step(1'b0, 2'd1, 2'd0, 8'd1, 1'b1);

        // Reset mid-scan at channel 2.
        for (int k = 0; k < 20 && m_ch[0] != 2; k++) step(1'b0, 2'd1, 2'd0, 8'd1, 1'b1);
        chk("reach_ch2", 32'(ch4), 32'd2);
        step(1'b1, 2'd1, 2'd0, 8'd1, 1'b1);
        chk("midrst_ch",  32'(ch4), 32'd0);
        chk("midrst_val", 32'(v4), 32'd0);
        for (int k = 0; k < 4; k++) step(1'b0, 2'd1, 2'd0, 8'd1, 1'b1);

        // Randomised traffic, scan-heavy with occasional reset.
        for (int k = 0; k < 400; k++) begin
            logic [1:0] md;
            md = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd1;
            step(($urandom_range(0, 49) == 0), md, 2'($urandom),
                 8'($urandom_range(0, 3)), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
